// File: rtl/flash_cfg_ctrl.sv
// flash_cfg_ctrl: sole owner of the DMB configuration flash pins.
// Autoloads the power-on configuration bytes after reset or RELOAD, then
// serves single-byte VME read and program requests. Every pin and status
// output is a register loaded from the next-state decode, so the pins
// follow the state register with no combinational glitches.
module flash_cfg_ctrl #(
  parameter int               ADR_W     = 10,
  parameter int               NLOAD     = 16,
  parameter int               WAIT_CYC  = 4,
  parameter int               WE_CYC    = 3,
  parameter int               PROG_CYC  = 1250,
  parameter logic [ADR_W-1:0] UNLK1_ADR = 10'h155,
  parameter logic [ADR_W-1:0] UNLK2_ADR = 10'h0AA
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ,
  input  logic               REQ_WR,
  input  logic [ADR_W-1:0]   REQ_ADR,
  input  logic [7:0]         REQ_WDATA,
  input  logic               RELOAD,
  output logic               ACK,
  output logic [7:0]         RDATA,
  output logic               BUSY,
  output logic [8*NLOAD-1:0] LOAD_DATA,
  output logic               LOAD_DONE,
  output logic [ADR_W-1:0]   FM_ADR,
  output logic               FM_CE_B,
  output logic               FM_OE_B,
  output logic               FM_WE_B,
  output logic [7:0]         FM_DOUT,
  output logic               FM_DOE,
  input  logic [7:0]         FM_DIN
);

  // PROG_CYC is the longest dwell, so it sizes the shared cycle counter.
  localparam int CNT_W  = $clog2(PROG_CYC + 1);
  localparam int LIDX_W = $clog2(NLOAD);

  typedef enum logic [3:0] {
    LSTART = 4'd0, LRD  = 4'd1, LREC  = 4'd2,  IDLE  = 4'd3,
    RD     = 4'd4, RREC = 4'd5, WSET  = 4'd6,  WLOW  = 4'd7,
    WHOLD  = 4'd8, WREC = 4'd9, PWAIT = 4'd10, DONE  = 4'd11
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [LIDX_W-1:0]  lidx_r;
  logic [1:0]         widx_r, widx_s;
  logic [ADR_W-1:0]   req_adr_r;
  logic [7:0]         req_wdata_r;
  logic               reload_pend_r;
  logic               rd_last_s;

  logic               ce_b_s, oe_b_s, we_b_s, doe_s, ack_s, busy_s, load_done_s;
  logic [ADR_W-1:0]   adr_s, wr_adr_s;
  logic [7:0]         dout_s, wr_dat_s, rdata_s;
  logic [8*NLOAD-1:0] load_data_s;

  assign rd_last_s = (cnt_r == CNT_W'(WAIT_CYC - 1));

  // State register plus sequencing bookkeeping (counter, byte/write index, request latch, pending reload).
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r       <= LSTART;
      cnt_r         <= {CNT_W{1'b0}};
      lidx_r        <= {LIDX_W{1'b0}};
      widx_r        <= 2'd0;
      req_adr_r     <= {ADR_W{1'b0}};
      req_wdata_r   <= 8'h00;
      reload_pend_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      // Byte index restarts with each autoload and advances once per recovery cycle.
      if (state_r == LSTART) begin
        lidx_r <= {LIDX_W{1'b0}};
      end else if (state_r == LREC) begin
        lidx_r <= lidx_r + LIDX_W'(1);
      end else begin
        lidx_r <= lidx_r;
      end
      // Two bits wrap back to 0 after the fourth bus write, ready for the next program.
      widx_r <= widx_s;
      if (state_r == IDLE && state_s == WSET) begin
        req_adr_r   <= REQ_ADR;
        req_wdata_r <= REQ_WDATA;
      end else begin
        req_adr_r   <= req_adr_r;
        req_wdata_r <= req_wdata_r;
      end
      // A reload that cannot start now is remembered and wins the next IDLE cycle.
      if (state_r == IDLE) begin
        reload_pend_r <= (!reload_pend_r && REQ && RELOAD);
      end else if (RELOAD) begin
        reload_pend_r <= 1'b1;
      end else begin
        reload_pend_r <= reload_pend_r;
      end
    end
  end

  // Next-state decode; pending reload beats REQ, REQ beats a fresh RELOAD.
  always_comb begin
    state_s = state_r;
    case (state_r)
      LSTART: state_s = LRD;
      LRD:    if (rd_last_s) state_s = LREC; else state_s = LRD;
      LREC:   if (lidx_r == LIDX_W'(NLOAD - 1)) state_s = IDLE; else state_s = LRD;
      IDLE: begin
        if (reload_pend_r)    state_s = LSTART;
        else if (REQ)         state_s = REQ_WR ? WSET : RD;
        else if (RELOAD)      state_s = LSTART;
        else                  state_s = IDLE;
      end
      RD:     if (rd_last_s) state_s = RREC; else state_s = RD;
      RREC:   state_s = DONE;
      WSET:   state_s = WLOW;
      WLOW:   if (cnt_r == CNT_W'(WE_CYC - 1)) state_s = WHOLD; else state_s = WLOW;
      WHOLD:  state_s = WREC;
      WREC:   if (widx_r == 2'd3) state_s = PWAIT; else state_s = WSET;
      PWAIT:  if (cnt_r == CNT_W'(PROG_CYC - 1)) state_s = DONE; else state_s = PWAIT;
      DONE:   state_s = IDLE;
      default: state_s = LSTART;
    endcase
    if (state_s == state_r) cnt_s = cnt_r + CNT_W'(1); else cnt_s = {CNT_W{1'b0}};
  end

  // Output decode: next values of pins and status, keyed on the state being entered.
  always_comb begin
    ce_b_s      = 1'b1;
    oe_b_s      = 1'b1;
    we_b_s      = 1'b1;
    doe_s       = 1'b0;
    ack_s       = 1'b0;
    adr_s       = FM_ADR;
    dout_s      = FM_DOUT;
    busy_s      = (state_s != IDLE);
    rdata_s     = RDATA;
    load_data_s = LOAD_DATA;
    load_done_s = LOAD_DONE;

    if (state_r == WREC) widx_s = widx_r + 2'd1; else widx_s = widx_r;
    case (widx_s)
      2'd0:    begin wr_adr_s = UNLK1_ADR; wr_dat_s = 8'hAA;       end
      2'd1:    begin wr_adr_s = UNLK2_ADR; wr_dat_s = 8'h55;       end
      2'd2:    begin wr_adr_s = UNLK1_ADR; wr_dat_s = 8'hA0;       end
      2'd3:    begin wr_adr_s = req_adr_r; wr_dat_s = req_wdata_r; end
      default: begin wr_adr_s = UNLK1_ADR; wr_dat_s = 8'hAA;       end
    endcase

    // Data is taken on the last strobe-low cycle, before the pins release.
    if (state_r == RD && rd_last_s) rdata_s = FM_DIN; else rdata_s = RDATA;
    if (state_r == LRD && rd_last_s) begin
      load_data_s[{lidx_r, 3'b000} +: 8] = FM_DIN;
    end else begin
      load_data_s = LOAD_DATA;
    end
    if (state_s == LSTART) begin
      load_done_s = 1'b0;
    end else if (state_r == LREC && state_s == IDLE) begin
      load_done_s = 1'b1;
    end else begin
      load_done_s = LOAD_DONE;
    end

    case (state_s)
      // Autoload addresses move only in LSTART/LREC, while CE_B is high.
      LSTART: adr_s = {ADR_W{1'b0}};
      LREC:   adr_s = FM_ADR + ADR_W'(1);
      LRD:    begin ce_b_s = 1'b0; oe_b_s = 1'b0; end
      RD: begin
        ce_b_s = 1'b0;
        oe_b_s = 1'b0;
        if (state_r == IDLE) adr_s = REQ_ADR; else adr_s = FM_ADR;
      end
      WSET: begin
        ce_b_s = 1'b0;
        doe_s  = 1'b1;
        adr_s  = wr_adr_s;
        dout_s = wr_dat_s;
      end
      WLOW:   begin ce_b_s = 1'b0; we_b_s = 1'b0; doe_s = 1'b1; end
      WHOLD:  begin ce_b_s = 1'b0; doe_s = 1'b1; end
      DONE:   ack_s = 1'b1;
      IDLE, RREC, WREC, PWAIT: ack_s = 1'b0;
      default: ack_s = 1'b0;
    endcase
  end

  // Output registers; reset parks every strobe inactive immediately, aborting any write.
  always_ff @(posedge CLK) begin
    if (RST) begin
      FM_CE_B   <= 1'b1;
      FM_OE_B   <= 1'b1;
      FM_WE_B   <= 1'b1;
      FM_DOE    <= 1'b0;
      FM_ADR    <= {ADR_W{1'b0}};
      FM_DOUT   <= 8'h00;
      ACK       <= 1'b0;
      RDATA     <= 8'h00;
      BUSY      <= 1'b1;
      LOAD_DATA <= {(8*NLOAD){1'b0}};
      LOAD_DONE <= 1'b0;
    end else begin
      FM_CE_B   <= ce_b_s;
      FM_OE_B   <= oe_b_s;
      FM_WE_B   <= we_b_s;
      FM_DOE    <= doe_s;
      FM_ADR    <= adr_s;
      FM_DOUT   <= dout_s;
      ACK       <= ack_s;
      RDATA     <= rdata_s;
      BUSY      <= busy_s;
      LOAD_DATA <= load_data_s;
      LOAD_DONE <= load_done_s;
    end
  end

endmodule

// File: tb/tb_flash_cfg_ctrl.sv
// Scoreboard bench for flash_cfg_ctrl with a behavioural flash array.
module tb_flash_cfg_ctrl;

  localparam logic [127:0] LD_PAT = 128'h00001010000008080000040400020200;

  logic         CLK = 1'b0;
  logic         RST, REQ, REQ_WR, RELOAD;
  logic [9:0]   REQ_ADR;
  logic [7:0]   REQ_WDATA;
  logic         ACK, BUSY, LOAD_DONE, FM_CE_B, FM_OE_B, FM_WE_B, FM_DOE;
  logic [7:0]   RDATA, FM_DOUT, FM_DIN;
  logic [127:0] LOAD_DATA;
  logic [9:0]   FM_ADR;

  flash_cfg_ctrl dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_WR(REQ_WR), .REQ_ADR(REQ_ADR),
    .REQ_WDATA(REQ_WDATA), .RELOAD(RELOAD), .ACK(ACK), .RDATA(RDATA),
    .BUSY(BUSY), .LOAD_DATA(LOAD_DATA), .LOAD_DONE(LOAD_DONE),
    .FM_ADR(FM_ADR), .FM_CE_B(FM_CE_B), .FM_OE_B(FM_OE_B), .FM_WE_B(FM_WE_B),
    .FM_DOUT(FM_DOUT), .FM_DOE(FM_DOE), .FM_DIN(FM_DIN)
  );

  always #12 CLK = ~CLK;

  // Flash array: bytes 0..15 hold the configuration image, the rest addr^0x3C.
  logic [7:0] mem [0:1023];
  logic [7:0] img [0:15];
  assign FM_DIN = (!FM_CE_B && !FM_OE_B) ? mem[FM_ADR] : 8'hFF;

  typedef struct { int cyc; logic [7:0] data; bit chk_data; } ack_t;
  typedef struct { logic [9:0] adr; logic [7:0] data; } wr_t;
  typedef struct { int cyc; logic [127:0] data; } ld_t;
  ack_t exp_ack[$];
  wr_t  exp_wr[$];
  ld_t  exp_ld[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int inv_viol = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ACK monitor: each completion must match the oldest expected one.
  initial begin
    ack_t a;
    forever begin
      @(negedge CLK);
      if (ACK === 1'b1) begin
        if (exp_ack.size() == 0) begin
          chk("unexpected_ack", 128'd1, 128'd0);
        end else begin
          a = exp_ack.pop_front();
          chk("ack_cycle", cyc, a.cyc);
          if (a.chk_data) chk("rdata", RDATA, a.data);
        end
      end
    end
  end

  // Bus-write monitor: a WE_B rising edge closes one write (ignored if reset aborted it).
  initial begin
    logic prev_we = 1'b1;
    int   we_low = 0;
    wr_t  w;
    forever begin
      @(negedge CLK);
      if (FM_WE_B === 1'b0) begin
        we_low++;
      end else if (prev_we === 1'b0) begin
        if (RST !== 1'b1) begin
          if (exp_wr.size() == 0) begin
            chk("unexpected_write", 128'd1, 128'd0);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_adr", FM_ADR, w.adr);
            chk("wr_data", FM_DOUT, w.data);
            chk("we_low_width", we_low, 3);
          end
        end
        we_low = 0;
      end
      prev_we = FM_WE_B;
    end
  end

  // Read-burst monitor and pin invariants.
  initial begin
    logic prev_oe = 1'b1;
    int   oe_low = 0;
    forever begin
      @(negedge CLK);
      if (FM_OE_B === 1'b0 && FM_WE_B === 1'b0) inv_viol++;
      if (FM_DOE === 1'b1 && FM_OE_B !== 1'b1) inv_viol++;
      if (FM_OE_B === 1'b0) begin
        oe_low++;
        if (FM_CE_B !== 1'b0) inv_viol++;
      end else if (prev_oe === 1'b0) begin
        chk("oe_low_width", oe_low, 4);
        oe_low = 0;
      end
      prev_oe = FM_OE_B;
    end
  end

  // Autoload monitor: every LOAD_DONE rise must match an expected completion.
  initial begin
    logic prev_ld = 1'b0;
    ld_t  l;
    forever begin
      @(negedge CLK);
      if (LOAD_DONE === 1'b1 && prev_ld !== 1'b1) begin
        if (exp_ld.size() == 0) begin
          chk("unexpected_load_done", 128'd1, 128'd0);
        end else begin
          l = exp_ld.pop_front();
          chk("load_done_cycle", cyc, l.cyc);
          chk("load_data", LOAD_DATA, l.data);
        end
      end
      prev_ld = LOAD_DONE;
    end
  end

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge CLK); #1;
      ok = (BUSY === 1'b0 && LOAD_DONE === 1'b1 && exp_ack.size() == 0 && exp_ld.size() == 0);
    end
    if (!ok) chk("timeout_idle", 128'd0, 128'd1);
  endtask

  task automatic issue(input bit wr, input logic [9:0] adr, input logic [7:0] wd,
                       input logic [7:0] erd, input bit push_ack, input int nwr, output int q);
    wr_t seq [4];
    REQ_WR = wr; REQ_ADR = adr; REQ_WDATA = wd; REQ = 1'b1;
    q = cyc;
    if (push_ack) begin
      if (wr) exp_ack.push_back('{q + 1275, 8'h00, 1'b0});
      else    exp_ack.push_back('{q + 6, erd, 1'b1});
    end
    seq[0] = '{10'h155, 8'hAA};
    seq[1] = '{10'h0AA, 8'h55};
    seq[2] = '{10'h155, 8'hA0};
    seq[3] = '{adr, wd};
    for (int i = 0; i < nwr; i++) exp_wr.push_back(seq[i]);
  endtask

  // Wait for ACK (bounded), release REQ in the ACK cycle, report OE_B-low cycles seen.
  task automatic wait_ack(output int oe_cnt);
    bit got = 1'b0;
    oe_cnt = 0;
    for (int n = 0; n < 1400 && !got; n++) begin
      @(negedge CLK); #1;
      if (FM_OE_B === 1'b0) oe_cnt++;
      got = (ACK === 1'b1);
    end
    REQ = 1'b0;
    if (!got) chk("timeout_ack", 128'd0, 128'd1);
  endtask

  task automatic release_rst(output int rel);
    RST = 1'b0;
    rel = cyc;
    exp_ld.push_back('{rel + 81, LD_PAT});
  endtask

  initial begin
    int rel, q, oel;
    img = '{8'h00, 8'h02, 8'h02, 8'h00, 8'h04, 8'h04, 8'h00, 8'h00,
            8'h08, 8'h08, 8'h00, 8'h00, 8'h10, 8'h10, 8'h00, 8'h00};
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] a;
      a = 10'(i);
      mem[i] = a[7:0] ^ 8'h3C;
    end
    for (int i = 0; i < 16; i++) mem[i] = img[i];
    RST = 1'b1; REQ = 1'b0; REQ_WR = 1'b0; REQ_ADR = 10'h000; REQ_WDATA = 8'h00; RELOAD = 1'b0;

    // Reset values.
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_ce_b", FM_CE_B, 1'b1);
    chk("rst_oe_b", FM_OE_B, 1'b1);
    chk("rst_we_b", FM_WE_B, 1'b1);
    chk("rst_doe", FM_DOE, 1'b0);
    chk("rst_adr", FM_ADR, 10'h000);
    chk("rst_dout", FM_DOUT, 8'h00);
    chk("rst_ack", ACK, 1'b0);
    chk("rst_rdata", RDATA, 8'h00);
    chk("rst_load_data", LOAD_DATA, 128'h0);
    chk("rst_load_done", LOAD_DONE, 1'b0);
    chk("rst_busy", BUSY, 1'b1);

    // Autoload, with a read REQ raised 10 cycles in that must wait for IDLE (entered at 81).
    release_rst(rel);
    repeat (10) @(negedge CLK);
    #1;
    REQ_WR = 1'b0; REQ_ADR = 10'h00C; REQ = 1'b1;
    exp_ack.push_back('{rel + 87, 8'h10, 1'b1});
    wait_ack(oel);

    // Plain reads inside and beyond the configuration image.
    wait_ready(); issue(1'b0, 10'h00C, 8'h00, 8'h10, 1'b1, 0, q); wait_ack(oel);
    wait_ready(); issue(1'b0, 10'h004, 8'h00, 8'h04, 1'b1, 0, q); wait_ack(oel);
    wait_ready(); issue(1'b0, 10'h2F0, 8'h00, 8'hCC, 1'b1, 0, q); wait_ack(oel);
    wait_ready(); issue(1'b0, 10'h3FF, 8'h00, 8'hC3, 1'b1, 0, q); wait_ack(oel);

    // Program 0x123 <- 0xA5.
    wait_ready(); issue(1'b1, 10'h123, 8'hA5, 8'h00, 1'b1, 4, q); wait_ack(oel);
    chk("prog_oe_stays_high", oel, 0);

    // RELOAD and REQ together: read first (ACK q+6), autoload cycle 0 at q+8.
    wait_ready();
    RELOAD = 1'b1;
    issue(1'b0, 10'h008, 8'h00, 8'h08, 1'b1, 0, q);
    exp_ld.push_back('{q + 89, LD_PAT});
    @(negedge CLK); #1;
    RELOAD = 1'b0;
    wait_ack(oel);

    // RELOAD pulse while BUSY is remembered and served after the read.
    wait_ready();
    issue(1'b0, 10'h00D, 8'h00, 8'h10, 1'b1, 0, q);
    exp_ld.push_back('{q + 89, LD_PAT});
    repeat (2) @(negedge CLK);
    #1;
    RELOAD = 1'b1;
    @(negedge CLK); #1;
    RELOAD = 1'b0;
    wait_ack(oel);

    // Reset during WLOW of the third write: only two writes complete, no ACK.
    wait_ready();
    issue(1'b1, 10'h200, 8'h3C, 8'h00, 1'b0, 2, q);
    repeat (15) @(negedge CLK);
    #1;
    RST = 1'b1; REQ = 1'b0;
    @(negedge CLK); #1;
    chk("midrst_ce_b", FM_CE_B, 1'b1);
    chk("midrst_oe_b", FM_OE_B, 1'b1);
    chk("midrst_we_b", FM_WE_B, 1'b1);
    chk("midrst_doe", FM_DOE, 1'b0);
    chk("midrst_load_data", LOAD_DATA, 128'h0);
    chk("midrst_load_done", LOAD_DONE, 1'b0);
    chk("midrst_ack", ACK, 1'b0);
    chk("midrst_rdata", RDATA, 8'h00);
    release_rst(rel);

    wait_ready();
    repeat (5) @(negedge CLK);
    chk("pending_acks", exp_ack.size(), 0);
    chk("pending_writes", exp_wr.size(), 0);
    chk("pending_loads", exp_ld.size(), 0);
    chk("pin_invariants", inv_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flash_cfg_ctrl.md
# flash_cfg_ctrl

Sequencer and arbiter for the DMB parallel configuration flash (49BV512-class, 8-bit data, 10-bit board address). After reset it autoloads the power-on configuration bytes into a register bank, then serves single-byte read and program requests from the VME command decoder. It sits between the VME register decoder and the flash pins (OFMADR/OFMCE_B/OFMOE_B/OFMWE_B/IOFMD). It is the only driver of those pins, so VME and autoload accesses never collide.

## Interface
- ADR_W, 10: flash address width.
- NLOAD, 16: bytes autoloaded, from address 0 upward.
- WAIT_CYC, 4: read access cycles with CE_B/OE_B low (≥70 ns at 24 ns clock).
- WE_CYC, 3: WE_B low width in cycles.
- PROG_CYC, 1250: fixed byte-program wait in cycles (30 µs).
- UNLK1_ADR, 10'h155; UNLK2_ADR, 10'h0AA: unlock command addresses.

- CLK  in  1  system clock (FPGACLK domain); one clock; reset is synchronous and active-high.
- RST  in  1  synchronous active-high reset.
- REQ  in  1  access request, level; held until ACK.
- REQ_WR  in  1  1 = program, 0 = read; sampled with REQ.
- REQ_ADR  in  ADR_W  byte address.
- REQ_WDATA  in  8  program data.
- RELOAD  in  1  one-cycle pulse; rerun autoload.
- ACK  out  1  one-cycle completion pulse.
- RDATA  out  8  read data; valid with ACK, held until next read.
- BUSY  out  1  high whenever not IDLE.
- LOAD_DATA  out  8*NLOAD  byte i at [8i+7:8i].
- LOAD_DONE  out  1  autoload complete.
- FM_ADR  out  ADR_W  flash address.
- FM_CE_B, FM_OE_B, FM_WE_B  out  1 each  flash strobes.
- FM_DOUT  out  8  write data; FM_DOE  out  1  tristate enable for IOFMD.
- FM_DIN  in  8  flash data from IOFMD.

## Operation
- States: LSTART, LRD, LREC, IDLE, RD, RREC, WSET, WLOW, WHOLD, WREC, PWAIT, DONE.
- Reset state LSTART. Autoload runs after every reset release and on every accepted RELOAD. It reads bytes 0..NLOAD-1 with the read cycle below and writes each byte into LOAD_DATA. LOAD_DONE goes low at the start and rises after the last byte.
- Read cycle: FM_ADR set, CE_B=OE_B=0 for WAIT_CYC cycles. FM_DIN is captured on the last of those cycles. Then 1 recovery cycle with CE_B=OE_B=1.
- Program: four bus writes: (UNLK1,AA), (UNLK2,55), (UNLK1,A0), (REQ_ADR,REQ_WDATA).
- Each bus write:
  - WSET, 1 cycle: CE_B=0, FM_DOE=1, address and data stable.
  - WLOW, WE_CYC cycles: WE_B=0.
  - WHOLD, 1 cycle: WE_B=1, CE_B and data held.
  - WREC, 1 cycle: CE_B=1, FM_DOE=0.
- After the fourth write, PWAIT lasts PROG_CYC cycles with all strobes high. Then DONE.
- DONE: ACK=1 for one cycle, then IDLE.
- Arbitration in IDLE: REQ beats RELOAD. A RELOAD arriving while BUSY or losing to REQ sets a pending flag. The pending reload is served at the next IDLE, ahead of REQ. A REQ arriving during autoload waits; it is not dropped.
- Invariants: never OE_B=0 and WE_B=0 together; FM_DOE=1 implies OE_B=1; FM_ADR/FM_DOUT change only while CE_B=1 or in WSET.

## Timing
- Reset values: FM_CE_B=FM_OE_B=FM_WE_B=1, FM_DOE=0, FM_ADR=0, FM_DOUT=0, ACK=0, RDATA=0, LOAD_DATA=0, LOAD_DONE=0, BUSY=1, reload-pending=0.
- RST asserted mid-cycle: strobes return to reset values at the next edge, with no partial write completion. Autoload restarts after release.
- Read latency: REQ sampled in IDLE at cycle 0. Strobes are low in cycles 1..WAIT_CYC, recovery is cycle WAIT_CYC+1, ACK and RDATA are valid in cycle WAIT_CYC+2 (cycle 6 at defaults).
- Program latency: ACK in cycle 4*(WE_CYC+3)+PROG_CYC+1 (cycle 1275 at defaults).
- Autoload: first strobe in cycle 1 after RST deasserts. LOAD_DONE rises in cycle NLOAD*(WAIT_CYC+1)+1 (cycle 81 at defaults).
- Address increments wrap within ADR_W. REQ must be deasserted or changed in the cycle after ACK; otherwise it is accepted again as a new request.

## Test plan
- Autoload: flash model bytes 0..15 = 00 02 02 00 04 04 00 00 08 08 00 00 10 10 00 00, release RST -> LOAD_DONE at cycle 81, LOAD_DATA=128'h00001010000008080000040400020200.
- Read REQ_ADR=0x00C -> ACK at cycle 6, RDATA=0x10; CE_B/OE_B low exactly 4 cycles; FM_DOE=0 throughout.
- Program 0x123←0xA5 -> bus writes (155,AA),(0AA,55),(155,A0),(123,A5), each with WE_B low 3 cycles; ACK at cycle 1275; OE_B stays 1 throughout.
- REQ read asserted 10 cycles after reset release -> no flash strobes for it before LOAD_DONE; ACK 6 cycles after IDLE is entered.
- RELOAD and REQ in the same IDLE cycle -> REQ served first, then autoload reruns with LOAD_DONE low→high; a RELOAD pulse during BUSY is also served.
- RST during WLOW of the third write -> next edge all strobes high, FM_DOE=0, LOAD_DATA=0, no ACK; autoload restarts.
